// File: rtl/combo_check_pkg.sv
// ---------------------------------------------------------------------------
// combo_check_pkg
// Shared types and sizing constants for the combinational truth-table
// checker: the FSM state encoding, the number of input vectors walked,
// the vector index width and the width of the settle/mismatch counters.
// ---------------------------------------------------------------------------
package combo_check_pkg;

   // Checker FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } checkState_t;

   localparam int NUM_VECTORS = 8;
   localparam int VEC_W       = 3;
   localparam int CNT_W       = 4;

endpackage : combo_check_pkg

// File: rtl/combo_truth_checker_settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
// Load/count/expire counter that measures how long the current input vector
// has been held. It restarts from zero on every vector change and raises
// o_expire during the last of SETTLE_CYCLES counting cycles.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   i_load    in   clear the count (vector change / run start)
//   i_enable  in   count this cycle
//   o_expire  out  high on the final counting cycle
// ---------------------------------------------------------------------------
module settle_timer
   import combo_check_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_enable,
   output logic o_expire
);

   logic [CNT_W-1:0] r_count;
   logic             w_lastCycle;

   // The terminal count is SETTLE_CYCLES-1 because the count starts at zero
   // on the first held cycle. Legal SETTLE_CYCLES is 1..15, so it fits CNT_W.
   assign w_lastCycle = (r_count == CNT_W'(SETTLE_CYCLES - 1));
   assign o_expire    = i_enable && w_lastCycle;

   // Count while enabled, fold back to zero on expiry so the next vector
   // starts clean even if no explicit load arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= '0;
      end else if (i_enable) begin
         if (w_lastCycle) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

endmodule : settle_timer

// File: rtl/combo_truth_checker.sv
// ---------------------------------------------------------------------------
// combo_truth_checker
// Drives all eight {A,B,C} vectors into a 3-input combinational block, holds
// each for SETTLE_CYCLES cycles, samples Q once per vector and compares it to
// the EXPECTED truth table. Reports a per-vector fail mask, a mismatch count
// and a pass flag.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..15)
//   EXPECTED       bit i = expected Q for vector i = {A,B,C}
//
// Ports
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   start           in   begin a run (honoured in IDLE or DONE only)
//   q               in   output of the checked block
//   a, b, c         out  inputs to the checked block (vec[2], vec[1], vec[0])
//   busy            out  run in progress
//   done            out  results valid, held until restart or reset
//   pass            out  all eight vectors matched
//   mismatch_count  out  number of failing vectors (0..8)
//   fail_mask       out  bit i set when vector i mismatched
// ---------------------------------------------------------------------------
module combo_truth_checker
   import combo_check_pkg::*;
#(
   parameter int                     SETTLE_CYCLES = 4,
   parameter logic [NUM_VECTORS-1:0] EXPECTED      = 8'hE8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   q,
   output logic                   a,
   output logic                   b,
   output logic                   c,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [CNT_W-1:0]       mismatch_count,
   output logic [NUM_VECTORS-1:0] fail_mask
);

   checkState_t            r_state;
   checkState_t            w_nextState;

   logic [VEC_W-1:0]       r_vec;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_pass;
   logic [CNT_W-1:0]       r_mismatch;
   logic [NUM_VECTORS-1:0] r_failMask;

   logic                   w_accept;
   logic                   w_sampleExit;
   logic                   w_lastVec;
   logic                   w_qBad;
   logic [CNT_W-1:0]       w_newMismatch;
   logic                   w_timerLoad;
   logic                   w_timerEnable;
   logic                   w_expire;

   // A run may only be (re)started from a quiescent state; start during a
   // run is simply not looked at.
   assign w_accept     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_sampleExit = (r_state == ST_SAMPLE);
   assign w_lastVec    = (r_vec == VEC_W'(NUM_VECTORS - 1));
   assign w_qBad       = (q != EXPECTED[r_vec]);

   // The post-compare count is needed both for the count register and for
   // the pass flag, so the vector-7 result is included in pass.
   assign w_newMismatch = r_mismatch + CNT_W'(w_qBad);

   assign w_timerLoad   = w_accept || w_sampleExit;
   assign w_timerEnable = (r_state == ST_SETTLE);

   settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settleTimer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_timerLoad),
      .i_enable (w_timerEnable),
      .o_expire (w_expire)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: settle, one sample cycle, then either the next
   // vector or DONE after the last one.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_nextState = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (w_expire) w_nextState = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            w_nextState = w_lastVec ? ST_DONE : ST_SETTLE;
         end
         ST_DONE: begin
            if (w_accept) w_nextState = ST_SETTLE;
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Vector and result registers. Starting a run wipes the previous results
   // on the accepting edge; each sample exit folds one comparison in and
   // either advances the vector or closes the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_mismatch <= '0;
         r_failMask <= '0;
      end else if (w_accept) begin
         r_vec      <= '0;
         r_busy     <= 1'b1;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_mismatch <= '0;
         r_failMask <= '0;
      end else if (w_sampleExit) begin
         r_mismatch <= w_newMismatch;
         if (w_qBad) begin
            r_failMask[r_vec] <= 1'b1;
         end
         if (w_lastVec) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (w_newMismatch == '0);
         end else begin
            r_vec <= r_vec + 1'b1;
         end
      end
   end

   assign a              = r_vec[2];
   assign b              = r_vec[1];
   assign c              = r_vec[0];
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign mismatch_count = r_mismatch;
   assign fail_mask      = r_failMask;

endmodule : combo_truth_checker
